vga_scanout: RTL and testbench

- Raster scanout stage directly downstream of the dual-clock video SRAM.
- Generates VGA timing for one frame and issues read requests on the SRAM read port, clocked by this block's clk.
- Unpacks each 16-bit word into 16 monochrome pixels, MSB first.
- Drives hsync, vsync, active and pixel to the DAC/pin stage, all phase-aligned.

---
 rtl/vga_scanout.sv | 196 +++++++++++++++++++
 tb/tb_vga_scanout.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_scanout: VGA raster timing, SRAM word fetch and MSB-first unpack.    |
// | Optional VGA_SCANOUT_PIXDBL_EN: 2x2 pixel doubling.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int AWIDTH   = 15,
  parameter int DWIDTH   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              vram_re,
  output logic [AWIDTH-1:0] vram_raddr,
  input  logic [DWIDTH-1:0] vram_rdata,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              pixel,
  output logic              frame_start
);

  localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int C_HW      = $clog2(C_H_TOTAL);
  localparam int C_VW      = $clog2(C_V_TOTAL);

  localparam logic [C_HW-1:0] C_H_LAST  = C_HW'(C_H_TOTAL - 1);
  localparam logic [C_VW-1:0] C_V_LAST  = C_VW'(C_V_TOTAL - 1);
  localparam logic [C_HW-1:0] C_H_ACT   = C_HW'(H_ACTIVE);
  localparam logic [C_VW-1:0] C_V_ACT   = C_VW'(V_ACTIVE);
  localparam logic [C_HW-1:0] C_HS_BEG  = C_HW'(H_ACTIVE + H_FP);
  localparam logic [C_HW-1:0] C_HS_END  = C_HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [C_VW-1:0] C_VS_BEG  = C_VW'(V_ACTIVE + V_FP);
  localparam logic [C_VW-1:0] C_VS_END  = C_VW'(V_ACTIVE + V_FP + V_SYNC);

  // r_run holds the counters at the origin for one clock after reset release
  logic              r_run;
  logic [C_HW-1:0]   r_h;
  logic [C_VW-1:0]   r_v;
  logic [AWIDTH-1:0] r_ptr;
  logic [AWIDTH-1:0] r_last;
  logic [DWIDTH-1:0] r_sr;
  logic              r_vis_d1, r_vis_d2;
  logic              r_hs_d1, r_hs_d2;
  logic              r_vs_d1, r_vs_d2;
  logic              r_fs_d1, r_fs_d2;
  logic              r_fetch_d1;

  logic w_h_wrap, w_v_last, w_vis, w_fetch, w_hs, w_vs, w_fs;

  assign w_h_wrap = (r_h == C_H_LAST);
  assign w_v_last = (r_v == C_V_LAST);
  assign w_vis    = r_run && (r_h < C_H_ACT) && (r_v < C_V_ACT);
  assign w_hs     = !((r_h >= C_HS_BEG) && (r_h < C_HS_END));
  assign w_vs     = !((r_v >= C_VS_BEG) && (r_v < C_VS_END));
  assign w_fs     = r_run && (r_h == '0) && (r_v == '0);

`ifdef VGA_SCANOUT_PIXDBL_EN
  assign w_fetch  = w_vis && (r_h[4:0] == 5'd0);
`else
  assign w_fetch  = w_vis && (r_h[3:0] == 4'd0);
`endif

  assign vram_re    = w_fetch;
  assign vram_raddr = w_fetch ? r_ptr : r_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (w_h_wrap) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : r_v + C_VW'(1);
        end else begin
          r_h <= r_h + C_HW'(1);
        end
      end
    end
  end

`ifdef VGA_SCANOUT_PIXDBL_EN
  logic [AWIDTH-1:0] r_line_start;

  // Even lines rewind so the following odd line re-reads the same words
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr        <= '0;
      r_last       <= '0;
      r_line_start <= '0;
    end else begin
      if (w_fetch)
        r_last <= r_ptr;
      if (r_run && w_h_wrap && w_v_last) begin
        r_ptr        <= '0;
        r_line_start <= '0;
      end else if (r_run && w_h_wrap) begin
        if (!r_v[0])
          r_ptr <= r_line_start;
        else
          r_line_start <= r_ptr;
      end else if (w_fetch) begin
        r_ptr <= r_ptr + AWIDTH'(1);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr  <= '0;
      r_last <= '0;
    end else begin
      if (w_fetch)
        r_last <= r_ptr;
      if (r_run && w_h_wrap && w_v_last)
        r_ptr <= '0;
      else if (w_fetch)
        r_ptr <= r_ptr + AWIDTH'(1);
    end
  end
`endif

  // Two-stage alignment: stage 1 covers the SRAM read, stage 2 the unpack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vis_d1   <= 1'b0;
      r_vis_d2   <= 1'b0;
      r_hs_d1    <= 1'b1;
      r_hs_d2    <= 1'b1;
      r_vs_d1    <= 1'b1;
      r_vs_d2    <= 1'b1;
      r_fs_d1    <= 1'b0;
      r_fs_d2    <= 1'b0;
      r_fetch_d1 <= 1'b0;
    end else begin
      r_vis_d1   <= w_vis;
      r_vis_d2   <= r_vis_d1;
      r_hs_d1    <= w_hs;
      r_hs_d2    <= r_hs_d1;
      r_vs_d1    <= w_vs;
      r_vs_d2    <= r_vs_d1;
      r_fs_d1    <= w_fs;
      r_fs_d2    <= r_fs_d1;
      r_fetch_d1 <= w_fetch;
    end
  end

`ifdef VGA_SCANOUT_PIXDBL_EN
  logic r_h0_d1, r_h0_d2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h0_d1 <= 1'b0;
      r_h0_d2 <= 1'b0;
      r_sr    <= '0;
    end else begin
      r_h0_d1 <= r_h[0];
      r_h0_d2 <= r_h0_d1;
      if (r_fetch_d1)
        r_sr <= vram_rdata;
      else if (r_h0_d2)
        r_sr <= {r_sr[DWIDTH-2:0], 1'b0};
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr <= '0;
    end else begin
      if (r_fetch_d1)
        r_sr <= vram_rdata;
      else
        r_sr <= {r_sr[DWIDTH-2:0], 1'b0};
    end
  end
`endif

  assign hsync       = r_hs_d2;
  assign vsync       = r_vs_d2;
  assign active      = r_vis_d2;
  assign frame_start = r_fs_d2;
  assign pixel       = r_sr[DWIDTH-1] & r_vis_d2;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_scanout: reduced-raster bench with a position-based output model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vga_scanout;

  localparam int HA  = 64;
  localparam int HFP = 4;
  localparam int HS  = 8;
  localparam int HBP = 4;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 1;
  localparam int AW  = 15;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;
`ifdef VGA_SCANOUT_PIXDBL_EN
  localparam int WPL = HA / 32;
  localparam int PXW = 32;
`else
  localparam int WPL = HA / 16;
  localparam int PXW = 16;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          vram_re;
  logic [AW-1:0] vram_raddr;
  logic [15:0]   vram_rdata = '0;
  logic          hsync, vsync, active, pixel, frame_start;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .AWIDTH(AW), .DWIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .vram_re(vram_re), .vram_raddr(vram_raddr), .vram_rdata(vram_rdata),
    .hsync(hsync), .vsync(vsync), .active(active), .pixel(pixel),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input int a);
    int x;
`ifdef VGA_SCANOUT_PIXDBL_EN
    if (a == 0) return 16'h8000;
`else
    if (a == 0) return 16'h8001;
`endif
    if (a == 1) return 16'hFFFF;
    x = (a * 40503) ^ (a << 7) ^ 32'h5A5A;
    return x[15:0];
  endfunction

  function automatic int word_of(input int h, input int v);
`ifdef VGA_SCANOUT_PIXDBL_EN
    return (v / 2) * WPL + h / 32;
`else
    return v * WPL + h / 16;
`endif
  endfunction

  function automatic int bit_of(input int h);
`ifdef VGA_SCANOUT_PIXDBL_EN
    return 15 - (h / 2) % 16;
`else
    return 15 - h % 16;
`endif
  endfunction

  // SRAM: data for a read request is presented on the following clock
  always @(posedge clk)
    if (vram_re) vram_rdata <= mem_word(int'(vram_raddr));

  // Clocks since reset release; counter position = cyc-1, output position = cyc-3
  int cyc = 0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  int          exp_last = 0;
  int          first_re_cyc = -1, first_re_addr = -1, first_fs_cyc = -1;
  bit          acc_en = 1'b0;
  logic [31:0] pix_vec = '0;
  int act_cnt0 = 0, hs_cnt0 = 0, hs_first = -1, vs_cnt = 0, vs_first_line = -1;
  int last_fetch = -1, second_addr = -1, second_re = 0, nf_re = 0, nf_addr = -1;
  int line1_addr = -1, line2_addr = -1, fs_cnt = 0, fs_prev = -1, fs_gap = -1;

  always @(negedge clk) begin
    int pc, po, h, v, w;
    logic e_re, e_hs, e_vs, e_act, e_fs, e_pix;
    logic [15:0] wd;
    if (!reset_n) begin
      chk("rst_re", vram_re, 0);
      chk("rst_raddr", vram_raddr, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_active", active, 0);
      chk("rst_pixel", pixel, 0);
      chk("rst_fs", frame_start, 0);
      exp_last = 0;
      first_re_cyc = -1;
      first_fs_cyc = -1;
    end else begin
      pc = cyc - 1;
      e_re = 1'b0;
      if (pc >= 0) begin
        h = pc % HT;
        v = (pc / HT) % VT;
        e_re = (h < HA) && (v < VA) && (h % PXW == 0);
        if (e_re) exp_last = word_of(h, v);
      end
      chk("re", vram_re, e_re);
      chk("raddr", vram_raddr, exp_last);

      po = cyc - 3;
      e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_fs = 1'b0; e_pix = 1'b0;
      if (po >= 0) begin
        h = po % HT;
        v = (po / HT) % VT;
        e_act = (h < HA) && (v < VA);
        e_hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
        e_vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
        e_fs  = (h == 0) && (v == 0);
        if (e_act) begin
          w  = word_of(h, v);
          wd = mem_word(w);
          e_pix = wd[bit_of(h)];
        end
      end
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("active", active, e_act);
      chk("frame_start", frame_start, e_fs);
      chk("pixel", pixel, e_pix);

      if (vram_re && first_re_cyc < 0) begin
        first_re_cyc  = cyc;
        first_re_addr = int'(vram_raddr);
      end
      if (frame_start && first_fs_cyc < 0) first_fs_cyc = cyc;

      if (acc_en) begin
        if (po >= 0 && po < 32) pix_vec[po] = pixel;
        if (po >= 0 && po < HT) begin
          if (active) act_cnt0++;
          if (!hsync) begin
            hs_cnt0++;
            if (hs_first < 0) hs_first = po;
          end
        end
        if (po >= 0 && po < FT && !vsync) begin
          vs_cnt++;
          if (vs_first_line < 0) vs_first_line = po / HT;
        end
        if (pc >= 0 && pc < FT && vram_re) last_fetch = int'(vram_raddr);
        if (pc == PXW) begin second_re = int'(vram_re); second_addr = int'(vram_raddr); end
        if (pc == HT) line1_addr = int'(vram_raddr);
        if (pc == 2 * HT) line2_addr = int'(vram_raddr);
        if (pc == FT) begin nf_re = int'(vram_re); nf_addr = int'(vram_raddr); end
        if (po >= 0 && frame_start) begin
          fs_cnt++;
          if (fs_prev >= 0) fs_gap = po - fs_prev;
          fs_prev = po;
        end
      end
    end
  end

  initial begin
    bit found;
    #1 reset_n = 1'b0;
    acc_en = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2 * FT + 25) @(negedge clk);
    acc_en = 1'b0;

    chk("first_fetch_cycle", first_re_cyc, 1);
    chk("first_fetch_addr", first_re_addr, 0);
    chk("second_fetch_re", second_re, 1);
    chk("second_fetch_addr", second_addr, 1);
`ifdef VGA_SCANOUT_PIXDBL_EN
    chk("line0_pixels", pix_vec, 32'h0000_0003);
    chk("last_fetch_addr", last_fetch, 5);
    chk("line1_first_addr", line1_addr, 0);
    chk("line2_first_addr", line2_addr, 2);
`else
    chk("line0_pixels", pix_vec, 32'hFFFF_8001);
    chk("last_fetch_addr", last_fetch, 23);
    chk("line1_first_addr", line1_addr, 4);
    chk("line2_first_addr", line2_addr, 8);
`endif
    chk("line0_active_cnt", act_cnt0, 64);
    chk("hsync_first_h", hs_first, 68);
    chk("hsync_low_cnt", hs_cnt0, 8);
    chk("vsync_low_cnt", vs_cnt, 160);
    chk("vsync_first_line", vs_first_line, 7);
    chk("next_frame_re", nf_re, 1);
    chk("next_frame_addr", nf_addr, 0);
    chk("frame_start_cnt", fs_cnt, 3);
    chk("frame_start_gap", fs_gap, FT);

    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      @(negedge clk);
      if ((cyc - 1) % FT == 3 * HT + 30) found = 1'b1;
    end
    chk("midrst_reached", found, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_re", vram_re, 0);
    chk("midrst_raddr", vram_raddr, 0);
    chk("midrst_hsync", hsync, 1);
    chk("midrst_vsync", vsync, 1);
    chk("midrst_active", active, 0);
    chk("midrst_pixel", pixel, 0);
    chk("midrst_fs", frame_start, 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (FT + 20) @(negedge clk);
    chk("post_rst_fetch_cycle", first_re_cyc, 1);
    chk("post_rst_fetch_addr", first_re_addr, 0);
    chk("post_rst_fs_delay", first_fs_cyc - first_re_cyc, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
